// File: rtl/uart_report_pkg.sv
// Shared types and constants for the sensor report framer.
// Frame length depends on UART_REPORT_CHKSUM_EN (checksum bytes before CR/LF).
package uart_report_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO,
    NEXT
  } state_e;

  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  localparam int FRAME_LEN_BASE = 9;
  localparam int FRAME_LEN_CHK  = 11;
  localparam int IDX_W          = 4;

endpackage

// File: rtl/hex_nib2ascii.sv
// Nibble to uppercase ASCII hex digit.
// Purely combinational.
module hex_nib2ascii (
  input  logic [3:0] nib_i,
  output logic [7:0] asc_o
);

  assign asc_o = (nib_i < 4'd10) ? 8'h30 + {4'h0, nib_i}
                                 : 8'h37 + {4'h0, nib_i};

endmodule

// File: rtl/uart_report_seq.sv
// Formats one sensor sample per frame and feeds it bytewise to a uart_tx.
// Optional checksum chars enabled by defining UART_REPORT_CHKSUM_EN.
module uart_report_seq
  import uart_report_pkg::*;
#(
  parameter int         OVR_W    = 8,
  parameter logic [7:0] HDR_CHAR = 8'h53
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_stb,
  input  logic [3:0]       sample_id,
  input  logic [15:0]      sample_data,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic             frame_busy,
  output logic [OVR_W-1:0] overrun_cnt
);

`ifdef UART_REPORT_CHKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       id_q;
  logic [15:0]      data_q;
  logic             pend_v_q;
  logic [3:0]       pend_id_q;
  logic [15:0]      pend_data_q;
  logic [OVR_W-1:0] ovr_q;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;

  logic [IDX_W-1:0] sel;
  logic [7:0]       byte_sel;
  logic [3:0]       nib [5];
  logic [7:0]       asc [5];

  assign nib[0] = id_q;
  assign nib[1] = data_q[15:12];
  assign nib[2] = data_q[11:8];
  assign nib[3] = data_q[7:4];
  assign nib[4] = data_q[3:0];

  for (genvar g = 0; g < 5; g++) begin : g_hex
    hex_nib2ascii u_hex (
      .nib_i (nib[g]),
      .asc_o (asc[g])
    );
  end

`ifdef UART_REPORT_CHKSUM_EN
  logic [7:0] ck;
  logic [7:0] ck_hi;
  logic [7:0] ck_lo;

  assign ck = HDR_CHAR ^ asc[0] ^ ASC_COLON
            ^ asc[1] ^ asc[2] ^ asc[3] ^ asc[4];

  hex_nib2ascii u_ck_hi (
    .nib_i (ck[7:4]),
    .asc_o (ck_hi)
  );

  hex_nib2ascii u_ck_lo (
    .nib_i (ck[3:0]),
    .asc_o (ck_lo)
  );
`endif

  // Byte for the index about to be started (NEXT -> START).
  assign sel = idx_q + IDX_W'(1);

  always_comb begin
    byte_sel = 8'h00;
    case (sel)
      4'd0: byte_sel = HDR_CHAR;
      4'd1: byte_sel = asc[0];
      4'd2: byte_sel = ASC_COLON;
      4'd3: byte_sel = asc[1];
      4'd4: byte_sel = asc[2];
      4'd5: byte_sel = asc[3];
      4'd6: byte_sel = asc[4];
`ifdef UART_REPORT_CHKSUM_EN
      4'd7:  byte_sel = ck_hi;
      4'd8:  byte_sel = ck_lo;
      4'd9:  byte_sel = ASC_CR;
      4'd10: byte_sel = ASC_LF;
`else
      4'd7: byte_sel = ASC_CR;
      4'd8: byte_sel = ASC_LF;
`endif
      default: byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      id_q        <= '0;
      data_q      <= '0;
      pend_v_q    <= 1'b0;
      pend_id_q   <= '0;
      pend_data_q <= '0;
      ovr_q       <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= 8'h00;
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pend_v_q || sample_stb) begin
            id_q       <= pend_v_q ? pend_id_q : sample_id;
            data_q     <= pend_v_q ? pend_data_q : sample_data;
            idx_q      <= '0;
            state_q    <= START;
            tx_start_q <= 1'b1;
            tx_data_q  <= HDR_CHAR;
          end
          // Loading the buffer frees it for a coincident strobe.
          if (pend_v_q) begin
            pend_v_q <= sample_stb;
            if (sample_stb) begin
              pend_id_q   <= sample_id;
              pend_data_q <= sample_data;
            end
          end
        end
        START:   state_q <= WAIT_HI;
        WAIT_HI: if (tx_busy) state_q <= WAIT_LO;
        WAIT_LO: if (!tx_busy) state_q <= NEXT;
        NEXT: begin
          if (idx_q == LAST_IDX) begin
            state_q <= IDLE;
          end else begin
            idx_q      <= sel;
            state_q    <= START;
            tx_start_q <= 1'b1;
            tx_data_q  <= byte_sel;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (state_q != IDLE && sample_stb) begin
        if (!pend_v_q) begin
          pend_v_q    <= 1'b1;
          pend_id_q   <= sample_id;
          pend_data_q <= sample_data;
        end else if (ovr_q != '1) begin
          ovr_q <= ovr_q + OVR_W'(1);
        end
      end
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign overrun_cnt = ovr_q;
  assign frame_busy  = (state_q != IDLE) || pend_v_q;

endmodule

// File: tb/tb_uart_report_seq.sv
// Directed bench for uart_report_seq with a simple uart_tx busy model.
// Expected frames follow UART_REPORT_CHKSUM_EN when it is defined.
module tb_uart_report_seq;
  import uart_report_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_stb;
  logic [3:0]  sample_id;
  logic [15:0] sample_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic [7:0]  overrun_cnt;
  logic        tx_start2;
  logic [7:0]  tx_data2;
  logic        frame_busy2;
  logic [1:0]  overrun_cnt2;

  uart_report_seq #(.OVR_W(8), .HDR_CHAR(8'h53)) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_stb  (sample_stb),
    .sample_id   (sample_id),
    .sample_data (sample_data),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .frame_busy  (frame_busy),
    .overrun_cnt (overrun_cnt)
  );

  uart_report_seq #(.OVR_W(2), .HDR_CHAR(8'h53)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .sample_stb  (sample_stb),
    .sample_id   (sample_id),
    .sample_data (sample_data),
    .tx_start    (tx_start2),
    .tx_data     (tx_data2),
    .tx_busy     (tx_busy),
    .frame_busy  (frame_busy2),
    .overrun_cnt (overrun_cnt2)
  );

  always #5 clk = ~clk;

`ifdef UART_REPORT_CHKSUM_EN
  localparam int EXP_LEN = 11;
`else
  localparam int EXP_LEN = 9;
`endif

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got_v,
                     input logic [31:0] exp_v);
    n_chk++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // uart_tx model: busy rises 2 cycles after start, lasts 3 cycles.
  int   bcnt = 0;
  logic model_en = 1'b1;
  logic man_busy = 1'b0;

  always @(posedge clk) begin
    if (tx_start) bcnt <= 5;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end

  assign tx_busy = model_en ? (bcnt >= 1 && bcnt <= 3) : man_busy;

  logic [7:0] got [$];

  always @(posedge clk) begin
    if (tx_start) got.push_back(tx_data);
  end

  logic [7:0] exp_b [11];
  logic [7:0] ref33 [11];

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h41 + 8'(n) - 8'd10;
  endfunction

  task automatic make_exp(input logic [3:0] id, input logic [15:0] d);
    logic [7:0] x;
    exp_b[0] = 8'h53;
    exp_b[1] = hexc(id);
    exp_b[2] = 8'h3A;
    exp_b[3] = hexc(d[15:12]);
    exp_b[4] = hexc(d[11:8]);
    exp_b[5] = hexc(d[7:4]);
    exp_b[6] = hexc(d[3:0]);
    x = 8'h00;
    for (int i = 0; i < 7; i++) x = x ^ exp_b[i];
`ifdef UART_REPORT_CHKSUM_EN
    exp_b[7]  = hexc(x[7:4]);
    exp_b[8]  = hexc(x[3:0]);
    exp_b[9]  = 8'h0D;
    exp_b[10] = 8'h0A;
`else
    exp_b[7]  = 8'h0D;
    exp_b[8]  = 8'h0A;
    exp_b[9]  = 8'h00;
    exp_b[10] = 8'h00;
`endif
  endtask

  task automatic chk_frame(input string tag, input int base);
    logic [7:0] g;
    for (int i = 0; i < EXP_LEN; i++) begin
      g = (base + i < got.size()) ? got[base + i] : 8'hxx;
      chk($sformatf("%s[%0d]", tag, i), {24'h0, g}, {24'h0, exp_b[i]});
    end
  endtask

  task automatic strobe(input logic [3:0] id, input logic [15:0] d);
    @(negedge clk);
    sample_stb  = 1'b1;
    sample_id   = id;
    sample_data = d;
    @(negedge clk);
    sample_stb  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!frame_busy) break;
      @(negedge clk);
    end
    chk(tag, {31'h0, frame_busy}, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int base;
  int nb;

  initial begin
`ifdef UART_REPORT_CHKSUM_EN
    ref33 = '{8'h53, 8'h33, 8'h3A, 8'h31, 8'h41, 8'h32, 8'h46,
              8'h35, 8'h45, 8'h0D, 8'h0A};
`else
    ref33 = '{8'h53, 8'h33, 8'h3A, 8'h31, 8'h41, 8'h32, 8'h46,
              8'h0D, 8'h0A, 8'h00, 8'h00};
`endif
    rst         = 1'b1;
    sample_stb  = 1'b0;
    sample_id   = 4'h0;
    sample_data = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
    chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst_frame_busy", {31'h0, frame_busy}, 32'h0);
    chk("rst_ovr", {24'h0, overrun_cnt}, 32'h0);
    rst = 1'b0;

    // Latency and reference frame.
    base = got.size();
    @(negedge clk);
    sample_stb  = 1'b1;
    sample_id   = 4'h3;
    sample_data = 16'h1A2F;
    @(negedge clk);
    sample_stb = 1'b0;
    chk("lat_start", {31'h0, tx_start}, 32'h1);
    chk("lat_data", {24'h0, tx_data}, 32'h53);
    @(negedge clk);
    chk("lat_start_off", {31'h0, tx_start}, 32'h0);
    wait_idle("ref_idle", 400);
    chk("ref_len", got.size() - base, EXP_LEN);
    for (int i = 0; i < EXP_LEN; i++)
      chk($sformatf("ref[%0d]", i), {24'h0, got[base + i]},
          {24'h0, ref33[i]});

    // Three strobes in one frame: second kept, third dropped.
    base = got.size();
    strobe(4'h1, 16'h0001);
    strobe(4'h2, 16'hBEEF);
    strobe(4'h4, 16'h1234);
    chk("ovr_one", {24'h0, overrun_cnt}, 32'h1);
    chk("ovr_one_w2", {30'h0, overrun_cnt2}, 32'h1);
    chk("ovr_busy", {31'h0, frame_busy}, 32'h1);
    wait_idle("ovr_idle", 1000);
    chk("ovr_len", got.size() - base, 2 * EXP_LEN);
    make_exp(4'h1, 16'h0001);
    chk_frame("ovr_f1", base);
    make_exp(4'h2, 16'hBEEF);
    chk_frame("ovr_f2", base + EXP_LEN);

    // Saturation: five drops on top of a stored sample.
    do_reset();
    chk("sat_rst_ovr", {24'h0, overrun_cnt}, 32'h0);
    strobe(4'h5, 16'h5555);
    strobe(4'h6, 16'h6666);
    repeat (5) strobe(4'h9, 16'h9999);
    chk("sat_ovr8", {24'h0, overrun_cnt}, 32'h5);
    chk("sat_ovr2", {30'h0, overrun_cnt2}, 32'h3);
    wait_idle("sat_idle", 1000);
    chk("sat_idle_w2", {31'h0, frame_busy2}, 32'h0);

    // Strobe exactly in the final NEXT cycle.
    do_reset();
    base = got.size();
    strobe(4'hA, 16'h0F0F);
    for (int k = 0; k < 400; k++) begin
      if (dut.state_q == NEXT && dut.idx_q == 4'(EXP_LEN - 1)) break;
      @(negedge clk);
    end
    sample_stb  = 1'b1;
    sample_id   = 4'hB;
    sample_data = 16'hFACE;
    @(negedge clk);
    sample_stb = 1'b0;
    chk("last_ovr", {24'h0, overrun_cnt}, 32'h0);
    chk("last_busy", {31'h0, frame_busy}, 32'h1);
    wait_idle("last_idle", 1000);
    chk("last_len", got.size() - base, 2 * EXP_LEN);
    make_exp(4'hB, 16'hFACE);
    chk_frame("last_f2", base + EXP_LEN);

    // Reset during byte 4 aborts the frame.
    do_reset();
    base = got.size();
    strobe(4'h7, 16'hC0DE);
    for (int k = 0; k < 200; k++) begin
      if (got.size() >= base + 4) break;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_tx_start", {31'h0, tx_start}, 32'h0);
    chk("abort_tx_data", {24'h0, tx_data}, 32'h0);
    chk("abort_busy", {31'h0, frame_busy}, 32'h0);
    rst = 1'b0;
    nb = got.size();
    repeat (30) @(negedge clk);
    chk("abort_no_start", got.size() - nb, 0);
    base = got.size();
    strobe(4'h7, 16'hC0DE);
    wait_idle("abort_idle", 400);
    chk("abort_len", got.size() - base, EXP_LEN);
    make_exp(4'h7, 16'hC0DE);
    chk_frame("abort_f", base);

    // tx_busy held low: FSM waits without restarting.
    model_en = 1'b0;
    man_busy = 1'b0;
    base = got.size();
    strobe(4'h2, 16'h3456);
    repeat (20) @(negedge clk);
    chk("hold_starts", got.size() - base, 1);
    chk("hold_state", {29'h0, dut.state_q}, {29'h0, WAIT_HI});
    man_busy = 1'b1;
    repeat (2) @(negedge clk);
    man_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (got.size() >= base + 2) break;
      @(negedge clk);
    end
    chk("hold_next", got.size() - base, 2);
    model_en = 1'b1;
    wait_idle("hold_idle", 400);
    chk("hold_len", got.size() - base, EXP_LEN);
    make_exp(4'h2, 16'h3456);
    chk_frame("hold_f", base);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_report_seq.md
UART_REPORT_SEQ -- requirements
Module: uart_report_seq

Interface
REQ-001 Parameter OVR_W, default 8, width of the overrun counter.
REQ-002 Parameter HDR_CHAR, default 8'h53 ('S'), first byte of every frame.
REQ-003 Port clk, input, 1: single system clock; all logic rising-edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port sample_stb, input, 1: one-cycle strobe; a new sensor reading is present.
REQ-006 Port sample_id, input, 4: sensor index, sampled with sample_stb.
REQ-007 Port sample_data, input, 16: raw sensor word, sampled with sample_stb.
REQ-008 Port tx_start, output, 1: one-cycle start pulse to uart_tx.
REQ-009 Port tx_data, output, 8: byte to uart_tx.
REQ-010 Port tx_busy, input, 1: busy flag from uart_tx.
REQ-011 Port frame_busy, output, 1: high while a frame is in progress or pending.
REQ-012 Port overrun_cnt, output, OVR_W: saturating count of dropped samples.

Function
REQ-013 Frame SHALL be HDR_CHAR, hex(id), ':', hex(d[15:12]), hex(d[11:8]), hex(d[7:4]), hex(d[3:0]), 0x0D, 0x0A (9 bytes).
REQ-014 Hex digits SHALL be uppercase ASCII: 0-9 -> 0x30+n; A-F -> 0x37+n.
REQ-015 FSM states SHALL be IDLE, START, WAIT_HI, WAIT_LO, NEXT.
REQ-016 IDLE: on sample_stb (or a held pending sample) SHALL latch id/data, set byte index 0, go to START.
REQ-017 START: tx_start=1 for exactly one cycle with tx_data = current byte; then WAIT_HI.
REQ-018 WAIT_HI: remain until tx_busy=1, then WAIT_LO; WAIT_LO: remain until tx_busy=0, then NEXT.
REQ-019 NEXT: if the last byte was sent, go to IDLE; else increment index and go to START.
REQ-020 Latency: sample_stb in IDLE at cycle N -> tx_start=1 with tx_data=HDR_CHAR at cycle N+1.
REQ-021 tx_data SHALL be stable from the START cycle until tx_busy falls.
REQ-022 One-entry pending buffer: a strobe while a frame is active and the buffer is empty SHALL store the sample.
REQ-023 A strobe while the buffer is full SHALL drop the sample and increment overrun_cnt, saturating at all-ones.
REQ-024 A strobe in the same cycle the last byte's NEXT returns to IDLE SHALL be stored as pending, never dropped.
REQ-025 From IDLE with a pending sample, START SHALL follow in the next cycle; the buffer SHALL empty on load.
REQ-026 frame_busy SHALL equal (state != IDLE) OR pending_valid.

Reset
REQ-027 On rst: state IDLE, tx_start=0, tx_data=0x00, pending cleared, overrun_cnt=0, frame_busy=0.
REQ-028 rst mid-frame SHALL abort the frame with no further tx_start; the remaining bytes are discarded.

Configuration
REQ-029 With UART_REPORT_CHKSUM_EN defined, two hex chars of the XOR of bytes 1-7 SHALL be inserted before CR (11-byte frame).
REQ-030 Without UART_REPORT_CHKSUM_EN, the frame SHALL be exactly the 9 bytes of REQ-013, with no checksum logic present.

Structure
REQ-031 Package uart_report_pkg SHALL hold the state enum, ASCII constants (':', CR, LF), and frame-length constants for both configurations.
REQ-032 Sub-module hex_nib2ascii (4-bit in, 8-bit ASCII out, combinational) SHALL be used for all hex conversion.

Verification
REQ-033 id=3, data=0x1A2F, uart_tx model -> bytes 53 33 3A 31 41 32 46 0D 0A, then frame_busy=0.
REQ-034 Same stimulus with UART_REPORT_CHKSUM_EN -> 53 33 3A 31 41 32 46 35 45 0D 0A (checksum 0x5E).
REQ-035 Strobe in IDLE at cycle N -> tx_start=1 and tx_data=0x53 at N+1, and tx_start=0 at N+2.
REQ-036 Three strobes during one frame -> second frame carries the second sample; overrun_cnt=1. With OVR_W=2 and 5 extra drops, overrun_cnt=3.
REQ-037 rst asserted during byte 4 -> tx_start stays 0 and all outputs return to reset values; a strobe after rst release -> a complete new frame.
REQ-038 tx_busy held low for 20 cycles after START -> FSM holds WAIT_HI with no repeat tx_start; busy 1 then 0 -> the next byte follows.
